// File: rtl/pipeline_pkg.sv
// Shared widths, FSM states and op encoding for the EX2 memory stage.
package pipeline_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned THR_W  = 3;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_INC,
        OP_LW,
        OP_SW
    } op_e;

    // Load wins over store, store over increment.
    function automatic op_e decode_op(
        input logic inc,
        input logic lw,
        input logic sw
    );
        if (lw)       return OP_LW;
        else if (sw)  return OP_SW;
        else if (inc) return OP_INC;
        else          return OP_NONE;
    endfunction

endpackage

// File: rtl/ex2_mem_stage.sv
// EX2 stage: increment, load/store via memory handshake, and
// per-thread register writeback; stalls upstream while memory is busy.
module ex2_mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned IMMEDIATE_WIDTH   = IMM_W,
    parameter int unsigned DATA_WIDTH        = DATA_W,
    parameter int unsigned REG_INDEX_BITS    = REG_W,
    parameter int unsigned THREAD_INDEX_BITS = THR_W,
    parameter int unsigned ADDR_WIDTH        = ADDR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_increment_flag,
    input  logic                         in_load_word_flag,
    input  logic                         in_store_word_flag,
    input  logic [IMMEDIATE_WIDTH-1:0]   in_immediate,
    input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
    input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
    input  logic [DATA_WIDTH-1:0]        in_reg_data,
    output logic                         out_stall,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_write,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    output logic [DATA_WIDTH-1:0]        mem_req_wdata,
    input  logic                         mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_resp_rdata,
    output logic                         wb_valid,
    output logic [THREAD_INDEX_BITS-1:0] wb_thread_index,
    output logic [REG_INDEX_BITS-1:0]    wb_reg_index,
    output logic [DATA_WIDTH-1:0]        wb_data
);

    state_e                         state_q, state_d;
    op_e                            op;

    logic [THREAD_INDEX_BITS-1:0]   thr_q, thr_d;
    logic [REG_INDEX_BITS-1:0]      reg_q, reg_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic                           write_q, write_d;

    logic                           wb_valid_q, wb_valid_d;
    logic [THREAD_INDEX_BITS-1:0]   wb_thr_q, wb_thr_d;
    logic [REG_INDEX_BITS-1:0]      wb_reg_q, wb_reg_d;
    logic [DATA_WIDTH-1:0]          wb_data_q, wb_data_d;

    assign op = decode_op(in_increment_flag,
                          in_load_word_flag,
                          in_store_word_flag);

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        reg_d      = reg_q;
        data_d     = data_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wb_valid_d = 1'b0;
        wb_thr_d   = wb_thr_q;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            IDLE: begin
                case (op)
                    OP_INC: begin
                        wb_valid_d = 1'b1;
                        wb_thr_d   = in_thread_index;
                        wb_reg_d   = in_reg_index;
                        wb_data_d  = in_reg_data + DATA_WIDTH'(1);
                    end
                    OP_LW, OP_SW: begin
                        thr_d   = in_thread_index;
                        reg_d   = in_reg_index;
                        data_d  = in_reg_data;
                        addr_d  = ADDR_WIDTH'(in_immediate);
                        write_d = (op == OP_SW);
                        state_d = REQ;
                    end
                    default: ;
                endcase
            end
            REQ: begin
                if (mem_req_ready)
                    state_d = write_q ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    wb_valid_d = 1'b1;
                    wb_thr_d   = thr_q;
                    wb_reg_d   = reg_q;
                    wb_data_d  = mem_resp_rdata;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            thr_q      <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_thr_q   <= '0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wb_valid_q <= wb_valid_d;
            wb_thr_q   <= wb_thr_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign out_stall       = (state_q != IDLE);
    assign mem_req_valid   = (state_q == REQ);
    assign mem_req_write   = write_q;
    assign mem_req_addr    = addr_q;
    assign mem_req_wdata   = data_q;
    assign wb_valid        = wb_valid_q;
    assign wb_thread_index = wb_thr_q;
    assign wb_reg_index    = wb_reg_q;
    assign wb_data         = wb_data_q;

endmodule

// File: tb/tb_ex2_mem_stage.sv
// Bench for ex2_mem_stage: vector table, directed corner sequences,
// and a random run against a transaction-level memory/writeback model.
module tb_ex2_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_increment_flag;
    logic        in_load_word_flag;
    logic        in_store_word_flag;
    logic [15:0] in_immediate;
    logic [2:0]  in_thread_index;
    logic [4:0]  in_reg_index;
    logic [63:0] in_reg_data;
    logic        out_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [15:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        wb_valid;
    logic [2:0]  wb_thread_index;
    logic [4:0]  wb_reg_index;
    logic [63:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex2_mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .in_increment_flag (in_increment_flag),
        .in_load_word_flag (in_load_word_flag),
        .in_store_word_flag(in_store_word_flag),
        .in_immediate      (in_immediate),
        .in_thread_index   (in_thread_index),
        .in_reg_index      (in_reg_index),
        .in_reg_data       (in_reg_data),
        .out_stall         (out_stall),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_write     (mem_req_write),
        .mem_req_addr      (mem_req_addr),
        .mem_req_wdata     (mem_req_wdata),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_rdata    (mem_resp_rdata),
        .wb_valid          (wb_valid),
        .wb_thread_index   (wb_thread_index),
        .wb_reg_index      (wb_reg_index),
        .wb_data           (wb_data)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic inc, input logic lw,
                          input logic sw, input logic [15:0] imm,
                          input logic [2:0] thr, input logic [4:0] rg,
                          input logic [63:0] data);
        in_increment_flag  = inc;
        in_load_word_flag  = lw;
        in_store_word_flag = sw;
        in_immediate       = imm;
        in_thread_index    = thr;
        in_reg_index       = rg;
        in_reg_data        = data;
    endtask

    task automatic clr_op();
        in_increment_flag  = 1'b0;
        in_load_word_flag  = 1'b0;
        in_store_word_flag = 1'b0;
    endtask

    typedef struct {
        logic        inc;
        logic        lw;
        logic        sw;
        logic [63:0] data;
        logic [2:0]  thr;
        logic [4:0]  rg;
        logic        exp_v;
        logic [63:0] exp_d;
    } vec_t;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [63:0] d;
    } req_t;

    typedef struct {
        logic [2:0]  t;
        logic [4:0]  r;
        logic [63:0] d;
    } wb_t;

    vec_t        vt[5];
    logic [63:0] shadow[8];
    logic [63:0] realm[8];
    req_t        req_q[$];
    wb_t         wb_q[$];

    initial begin
        vec_t   v;
        req_t   rq;
        wb_t    wq;
        logic   consumed;
        logic   pend;
        logic   hs;
        int     rwait;
        logic [2:0] paddr;
        logic [2:0] fl;

        reset = 1'b1;
        clr_op();
        in_immediate    = '0;
        in_thread_index = '0;
        in_reg_index    = '0;
        in_reg_data     = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_rdata  = '0;
        step();
        step();
        chk("rst_stall", out_stall, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_write", mem_req_write, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        reset = 1'b0;

        vt[0] = '{1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 3, 1, 64'h0};
        vt[1] = '{0, 0, 0, 64'h77, 1, 1, 0, 64'h0};
        vt[2] = '{1, 0, 0, 64'd41, 6, 30, 1, 64'd42};
        vt[3] = '{1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 7, 31, 1,
                  64'h8000_0000_0000_0000};
        vt[4] = '{0, 0, 0, 64'h5, 2, 2, 0, 64'h8000_0000_0000_0000};
        for (int i = 0; i < 5; i++) begin
            v = vt[i];
            set_op(v.inc, v.lw, v.sw, 16'h0, v.thr, v.rg, v.data);
            chk("vec_stall_pre", out_stall, 0);
            step();
            clr_op();
            chk("vec_wb_valid", wb_valid, v.exp_v);
            chk("vec_wb_data", wb_data, v.exp_d);
            chk("vec_stall", out_stall, 0);
            if (v.exp_v) begin
                chk("vec_wb_thr", wb_thread_index, v.thr);
                chk("vec_wb_reg", wb_reg_index, v.rg);
            end
        end

        // load with ready held low for three request cycles
        set_op(0, 1, 0, 16'h0040, 2, 7, 64'h99);
        mem_req_ready = 1'b0;
        step();
        clr_op();
        for (int i = 0; i < 4; i++) begin
            chk("ld_req_valid", mem_req_valid, 1);
            chk("ld_req_addr", mem_req_addr, 16'h0040);
            chk("ld_req_write", mem_req_write, 0);
            chk("ld_stall", out_stall, 1);
            chk("ld_no_wb", wb_valid, 0);
            mem_req_ready = (i == 3);
            step();
        end
        mem_req_ready = 1'b0;
        chk("ld_req_drop", mem_req_valid, 0);
        chk("ld_wait_stall", out_stall, 1);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEADBEEF;
        chk("ld_no_wb_early", wb_valid, 0);
        step();
        mem_resp_valid = 1'b0;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, 64'hDEADBEEF);
        chk("ld_wb_thr", wb_thread_index, 2);
        chk("ld_wb_reg", wb_reg_index, 7);
        chk("ld_done_stall", out_stall, 0);
        step();
        chk("ld_wb_single", wb_valid, 0);

        // store, ready immediately
        set_op(0, 0, 1, 16'h0010, 4, 9, 64'h1234);
        mem_req_ready = 1'b1;
        step();
        clr_op();
        chk("st_req_valid", mem_req_valid, 1);
        chk("st_req_write", mem_req_write, 1);
        chk("st_req_wdata", mem_req_wdata, 64'h1234);
        chk("st_req_addr", mem_req_addr, 16'h0010);
        chk("st_stall", out_stall, 1);
        step();
        chk("st_req_done", mem_req_valid, 0);
        chk("st_stall_done", out_stall, 0);
        chk("st_no_wb", wb_valid, 0);
        step();
        chk("st_no_wb2", wb_valid, 0);

        // load followed by an increment held during the stall
        set_op(0, 1, 0, 16'h0005, 0, 4, 64'h0);
        step();
        set_op(1, 0, 0, 16'h0, 1, 2, 64'd9);
        chk("b2b_stall_req", out_stall, 1);
        step();
        chk("b2b_stall_wait", out_stall, 1);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h55;
        step();
        mem_resp_valid = 1'b0;
        chk("b2b_ld_wb", wb_valid, 1);
        chk("b2b_ld_data", wb_data, 64'h55);
        chk("b2b_ld_reg", wb_reg_index, 4);
        chk("b2b_idle", out_stall, 0);
        step();
        clr_op();
        chk("b2b_inc_wb", wb_valid, 1);
        chk("b2b_inc_data", wb_data, 64'd10);
        chk("b2b_inc_thr", wb_thread_index, 1);
        step();
        chk("b2b_inc_once", wb_valid, 0);
        chk("b2b_no_req", mem_req_valid, 0);

        // reset while waiting for a load response
        set_op(0, 1, 0, 16'h0033, 3, 5, 64'h0);
        step();
        clr_op();
        step();
        chk("rw_in_wait", out_stall, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_wb_data_clr", wb_data, 0);
        chk("rw_stall_clr", out_stall, 0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD;
        step();
        mem_resp_valid = 1'b0;
        chk("rw_no_wb", wb_valid, 0);
        chk("rw_no_req", mem_req_valid, 0);
        chk("rw_stall", out_stall, 0);
        step();
        chk("rw_no_wb2", wb_valid, 0);

        // all flags set behaves as a load
        set_op(1, 1, 1, 16'h0022, 6, 12, 64'h7);
        mem_req_ready = 1'b0;
        step();
        clr_op();
        chk("all_req", mem_req_valid, 1);
        chk("all_is_load", mem_req_write, 0);
        chk("all_no_inc_wb", wb_valid, 0);
        mem_req_ready = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hABC;
        step();
        mem_resp_valid = 1'b0;
        chk("all_wb", wb_valid, 1);
        chk("all_wb_data", wb_data, 64'hABC);
        chk("all_wb_reg", wb_reg_index, 12);

        // random run against the transaction model
        for (int i = 0; i < 8; i++) begin
            shadow[i] = '0;
            realm[i]  = '0;
        end
        pend  = 1'b0;
        rwait = 0;
        paddr = '0;
        clr_op();
        step();
        for (int c = 0; c < 3000; c++) begin
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            mem_resp_valid = 1'b0;
            if (pend) begin
                if (rwait == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = realm[paddr];
                    pend = 1'b0;
                end else begin
                    rwait--;
                end
            end
            consumed = !out_stall;
            if (consumed) begin
                if (in_load_word_flag) begin
                    rq = '{1'b0, in_immediate, 64'h0};
                    req_q.push_back(rq);
                    wq = '{in_thread_index, in_reg_index,
                           shadow[in_immediate[2:0]]};
                    wb_q.push_back(wq);
                end else if (in_store_word_flag) begin
                    rq = '{1'b1, in_immediate, in_reg_data};
                    req_q.push_back(rq);
                    shadow[in_immediate[2:0]] = in_reg_data;
                end else if (in_increment_flag) begin
                    wq = '{in_thread_index, in_reg_index,
                           in_reg_data + 64'd1};
                    wb_q.push_back(wq);
                end
            end
            hs = mem_req_valid && mem_req_ready;
            if (hs) begin
                chk("rnd_req_expected", req_q.size() != 0, 1);
                if (req_q.size() != 0) begin
                    rq = req_q.pop_front();
                    chk("rnd_req_write", mem_req_write, rq.w);
                    chk("rnd_req_addr", mem_req_addr, rq.a);
                    if (rq.w) begin
                        chk("rnd_req_wdata", mem_req_wdata, rq.d);
                        realm[mem_req_addr[2:0]] = mem_req_wdata;
                    end else begin
                        pend  = 1'b1;
                        paddr = mem_req_addr[2:0];
                        rwait = $urandom_range(0, 2);
                    end
                end
            end
            step();
            if (wb_valid) begin
                chk("rnd_wb_expected", wb_q.size() != 0, 1);
                if (wb_q.size() != 0) begin
                    wq = wb_q.pop_front();
                    chk("rnd_wb_thr", wb_thread_index, wq.t);
                    chk("rnd_wb_reg", wb_reg_index, wq.r);
                    chk("rnd_wb_data", wb_data, wq.d);
                end
            end
            if (consumed) begin
                fl = 3'($urandom_range(0, 7));
                if (c >= 2950) fl = 3'b000;
                set_op(fl[0], fl[1], fl[2],
                       16'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)),
                       5'($urandom_range(0, 31)),
                       {$urandom(), $urandom()});
            end
        end
        chk("rnd_wb_drained", wb_q.size(), 0);
        chk("rnd_req_drained", req_q.size(), 0);
        chk("rnd_resp_drained", pend, 0);
        chk("rnd_end_stall", out_stall, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
